// File: rtl/io_pkg.sv
// Shared definitions for the IN/OUT port handshake sequencer and the control unit.
package io_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StWrWait = 2'd2,
        StDone   = 2'd3
    } io_state_e;

    // A timed-out read returns every bit of in_data set to this value.
    localparam logic TIMEOUT_RD_FILL = 1'b1;

    localparam logic [3:0] OP_IN  = 4'b1110;
    localparam logic [3:0] OP_OUT = 4'b1111;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/io_timeout_cnt.sv
// Loadable saturating wait counter; expired flags the last permitted cycle.
module io_timeout_cnt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    localparam logic [WIDTH-1:0] LAST = (LIMIT == 0) ? '0 : WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // LIMIT of zero disables expiry entirely.
    assign expired = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/io_port_ctrl.sv
// Sequences IN/OUT handshakes to external devices, stalling the control unit until done.
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PORT_W  = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_req,
    input  logic                        out_req,
    input  logic [PORT_W-1:0]           port_sel,
    input  logic [DATA_W-1:0]           out_data,
    output logic [DATA_W-1:0]           in_data,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err,
    output logic                        proto_err,
    input  logic                        err_clr,
    output logic [2**PORT_W-1:0]        dev_rd_req,
    input  logic [2**PORT_W-1:0]        dev_rd_valid,
    input  logic [2**PORT_W*DATA_W-1:0] dev_rd_data,
    output logic [2**PORT_W-1:0]        dev_wr_req,
    output logic [DATA_W-1:0]           dev_wr_data,
    input  logic [2**PORT_W-1:0]        dev_wr_ack
);

    localparam int unsigned NPORTS = 2**PORT_W;
    localparam int unsigned CNT_W  = cnt_width(TIMEOUT);

    io_state_e           state_q, state_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic [DATA_W-1:0]   in_data_q, in_data_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                timeout_err_q, proto_err_q;
    logic                cnt_clr, cnt_en, cnt_expired;
    logic                timeout_set, proto_set;
    logic [NPORTS-1:0]   port_onehot;

    io_timeout_cnt #(
        .WIDTH (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .en       (cnt_en),
        .expired  (cnt_expired)
    );

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        in_data_d   = in_data_q;
        wr_data_d   = wr_data_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        timeout_set = 1'b0;
        proto_set   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_req) begin
                    // A colliding write is dropped; only the flag records it.
                    port_d    = port_sel;
                    state_d   = StRdWait;
                    cnt_clr   = 1'b1;
                    proto_set = out_req;
                end else if (out_req) begin
                    port_d    = port_sel;
                    wr_data_d = out_data;
                    state_d   = StWrWait;
                    cnt_clr   = 1'b1;
                end
            end
            StRdWait: begin
                if (dev_rd_valid[port_q]) begin
                    in_data_d = dev_rd_data[port_q*DATA_W +: DATA_W];
                    state_d   = StDone;
                end else if (cnt_expired) begin
                    in_data_d   = {DATA_W{TIMEOUT_RD_FILL}};
                    timeout_set = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StWrWait: begin
                if (dev_wr_ack[port_q]) begin
                    state_d = StDone;
                end else if (cnt_expired) begin
                    timeout_set = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            port_q        <= '0;
            in_data_q     <= '0;
            wr_data_q     <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            in_data_q <= in_data_d;
            wr_data_q <= wr_data_d;
            // Setting takes priority over a same-cycle clear.
            if (timeout_set) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
            if (proto_set) begin
                proto_err_q <= 1'b1;
            end else if (err_clr) begin
                proto_err_q <= 1'b0;
            end
        end
    end

    assign port_onehot = {{(NPORTS-1){1'b0}}, 1'b1} << port_q;

    assign dev_rd_req  = (state_q == StRdWait) ? port_onehot : '0;
    assign dev_wr_req  = (state_q == StWrWait) ? port_onehot : '0;
    assign dev_wr_data = wr_data_q;
    assign in_data     = in_data_q;
    assign done        = (state_q == StDone);
    assign busy        = (state_q != StIdle) | in_req | out_req;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;

endmodule
